// File: rtl/micro_sequencer_if.sv
// Sequencer bus between microcode ROM control fields and the micro-PC.
//   master: drives stall, op, addr_ctl, call_target; observes upc and status
//   slave : the sequencer; consumes controls, drives upc, illegal_op,
//           stack_err, stack_depth
interface micro_sequencer_if #(
    parameter int unsigned UADDR_W     = 4,
    parameter int unsigned STACK_DEPTH = 2
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               stall;
    logic [6:0]         op;
    logic [2:0]         addr_ctl;
    logic [UADDR_W-1:0] call_target;
    logic [UADDR_W-1:0] upc;
    logic               illegal_op;
    logic               stack_err;
    logic [DEPTH_W-1:0] stack_depth;

    modport master (
        output stall, op, addr_ctl, call_target,
        input  upc, illegal_op, stack_err, stack_depth
    );

    modport slave (
        input  stall, op, addr_ctl, call_target,
        output upc, illegal_op, stack_err, stack_depth
    );
endinterface

// File: rtl/micro_sequencer.sv
// Registered next-micro-address sequencer for the multicycle RISC-V control
// unit: micro-PC with stall, opcode dispatch, call/return stack and trapping.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of micro_sequencer_if
//            in : stall, op[6:0], addr_ctl[2:0], call_target
//            out: upc (ROM address), illegal_op (1-cycle pulse),
//                 stack_err (sticky), stack_depth
module micro_sequencer #(
    parameter int unsigned UADDR_W     = 4,
    parameter int unsigned STACK_DEPTH = 2,
    parameter int unsigned FETCH_ADDR  = 0,
    parameter int unsigned MEMADR_ADDR = 2,
    parameter int unsigned LW_ADDR     = 3,
    parameter int unsigned SW_ADDR     = 5,
    parameter int unsigned RTYPE_ADDR  = 6,
    parameter int unsigned ALUWB_ADDR  = 7,
    parameter int unsigned ITYPE_ADDR  = 8,
    parameter int unsigned JAL_ADDR    = 9,
    parameter int unsigned BTYPE_ADDR  = 10,
    parameter int unsigned TRAP_ADDR   = 15
) (
    input  logic               clk,
    input  logic               reset,
    micro_sequencer_if.slave   bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS   = 1 << SP_W;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_B  = 7'b1100011;

    typedef enum logic [2:0] {
        CTL_SEQ   = 3'b000,
        CTL_DISP1 = 3'b001,
        CTL_DISP2 = 3'b010,
        CTL_FETCH = 3'b011,
        CTL_ALUWB = 3'b100,
        CTL_CALL  = 3'b101,
        CTL_RET   = 3'b110,
        CTL_HOLD  = 3'b111
    } addr_ctl_e;

    addr_ctl_e          ctl;
    logic [UADDR_W-1:0] upc_q, upc_n, upc_inc, tos;
    logic [DEPTH_W-1:0] depth_q, depth_n;
    logic               ill_q, ill_n;
    logic               err_q, err_n;
    logic               push;
    logic               full, empty;
    logic [UADDR_W-1:0] stack_mem [SLOTS];

    assign ctl     = addr_ctl_e'(bus.addr_ctl);
    assign upc_inc = upc_q + UADDR_W'(1);
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);
    // Top of stack; index is meaningless when empty, but RET then traps.
    assign tos     = stack_mem[SP_W'(depth_q - DEPTH_W'(1))];

    // Next-address select, stack bookkeeping and fault flags.
    always_comb begin
        upc_n   = upc_q;
        depth_n = depth_q;
        ill_n   = 1'b0;
        err_n   = err_q;
        push    = 1'b0;
        if (!bus.stall) begin
            unique case (ctl)
                CTL_SEQ:   upc_n = upc_inc;
                CTL_DISP1: begin
                    case (bus.op)
                        OP_R:        upc_n = UADDR_W'(RTYPE_ADDR);
                        OP_I:        upc_n = UADDR_W'(ITYPE_ADDR);
                        OP_J:        upc_n = UADDR_W'(JAL_ADDR);
                        OP_B:        upc_n = UADDR_W'(BTYPE_ADDR);
                        OP_LW, OP_SW: upc_n = UADDR_W'(MEMADR_ADDR);
                        default: begin
                            upc_n = UADDR_W'(TRAP_ADDR);
                            ill_n = 1'b1;
                        end
                    endcase
                end
                CTL_DISP2: begin
                    case (bus.op)
                        OP_LW:   upc_n = UADDR_W'(LW_ADDR);
                        OP_SW:   upc_n = UADDR_W'(SW_ADDR);
                        default: begin
                            upc_n = UADDR_W'(TRAP_ADDR);
                            ill_n = 1'b1;
                        end
                    endcase
                end
                CTL_FETCH: upc_n = UADDR_W'(FETCH_ADDR);
                CTL_ALUWB: upc_n = UADDR_W'(ALUWB_ADDR);
                CTL_CALL: begin
                    if (full) begin
                        upc_n = UADDR_W'(TRAP_ADDR);
                        err_n = 1'b1;
                    end else begin
                        push    = 1'b1;
                        depth_n = depth_q + DEPTH_W'(1);
                        upc_n   = bus.call_target;
                    end
                end
                CTL_RET: begin
                    if (empty) begin
                        upc_n = UADDR_W'(TRAP_ADDR);
                        err_n = 1'b1;
                    end else begin
                        depth_n = depth_q - DEPTH_W'(1);
                        upc_n   = tos;
                    end
                end
                CTL_HOLD:  upc_n = upc_q;
                default:   upc_n = upc_q;
            endcase
        end
    end

    // Control/status registers; stall is already folded into the *_n values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q   <= UADDR_W'(FETCH_ADDR);
            depth_q <= '0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            upc_q   <= upc_n;
            depth_q <= depth_n;
            ill_q   <= ill_n;
            err_q   <= err_n;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[SP_W'(depth_q)] <= upc_inc;
        end
    end

    assign bus.upc         = upc_q;
    assign bus.illegal_op  = ill_q;
    assign bus.stack_err   = err_q;
    assign bus.stack_depth = depth_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vectors with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_micro_sequencer;
    localparam int unsigned UW = 4;
    localparam int unsigned SD = 2;
    localparam int          MODN = 1 << UW;

    localparam logic [2:0] SEQ = 3'd0, DISP1 = 3'd1, DISP2 = 3'd2, FETCH = 3'd3,
                           ALUWB = 3'd4, CALL = 3'd5, RET = 3'd6, HOLD = 3'd7;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    micro_sequencer_if #(.UADDR_W(UW), .STACK_DEPTH(SD)) bus ();

    micro_sequencer #(.UADDR_W(UW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue used as the LIFO.
    int m_upc;
    bit m_ill;
    bit m_err;
    int m_stk[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_upc = 0;
            m_ill = 0;
            m_err = 0;
            m_stk.delete();
        end else if (bus.stall) begin
            m_ill = 0;
        end else begin
            m_ill = 0;
            case (bus.addr_ctl)
                SEQ:   m_upc = (m_upc + 1) % MODN;
                DISP1: begin
                    if (bus.op == 7'b0110011)      m_upc = 6;
                    else if (bus.op == 7'b0010011) m_upc = 8;
                    else if (bus.op == 7'b1101111) m_upc = 9;
                    else if (bus.op == 7'b1100011) m_upc = 10;
                    else if (bus.op == 7'b0000011 || bus.op == 7'b0100011) m_upc = 2;
                    else begin m_upc = 15; m_ill = 1; end
                end
                DISP2: begin
                    if (bus.op == 7'b0000011)      m_upc = 3;
                    else if (bus.op == 7'b0100011) m_upc = 5;
                    else begin m_upc = 15; m_ill = 1; end
                end
                FETCH: m_upc = 0;
                ALUWB: m_upc = 7;
                CALL: begin
                    if (m_stk.size() == SD) begin
                        m_upc = 15;
                        m_err = 1;
                    end else begin
                        m_stk.push_back((m_upc + 1) % MODN);
                        m_upc = int'(bus.call_target);
                    end
                end
                RET: begin
                    if (m_stk.size() == 0) begin
                        m_upc = 15;
                        m_err = 1;
                    end else begin
                        m_upc = m_stk.pop_back();
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_upc",   int'(bus.upc),         m_upc);
        chk("model_ill",   int'(bus.illegal_op),  int'(m_ill));
        chk("model_err",   int'(bus.stack_err),   int'(m_err));
        chk("model_depth", int'(bus.stack_depth), m_stk.size());
    end

    // Drive one cycle of controls; returns at the following falling edge.
    task automatic cyc(input logic [2:0] c, input logic [6:0] o,
                       input logic [3:0] t, input logic s);
        bus.addr_ctl    = c;
        bus.op          = o;
        bus.call_target = t;
        bus.stall       = s;
        @(negedge clk);
    endtask

    logic [6:0] op_tab [8];

    initial begin
        total = 0;
        bad   = 0;
        op_tab[0] = 7'b0110011; op_tab[1] = 7'b0010011;
        op_tab[2] = 7'b1101111; op_tab[3] = 7'b1100011;
        op_tab[4] = 7'b0000011; op_tab[5] = 7'b0100011;
        op_tab[6] = 7'b1111111; op_tab[7] = 7'b0000000;

        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.op          = 7'd0;
        bus.addr_ctl    = HOLD;
        bus.call_target = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_upc",   int'(bus.upc), 0);
        chk("rst_depth", int'(bus.stack_depth), 0);
        chk("rst_ill",   int'(bus.illegal_op), 0);
        chk("rst_err",   int'(bus.stack_err), 0);

        // SEQ walk with wrap.
        for (int i = 1; i <= 16; i++) begin
            cyc(SEQ, 7'd0, 4'd0, 1'b0);
            chk("seq", int'(bus.upc), i % 16);
        end

        // Two-level dispatch for lw and sw.
        cyc(DISP1, 7'b0000011, 4'd0, 1'b0); chk("disp1_lw", int'(bus.upc), 2);
        cyc(DISP2, 7'b0000011, 4'd0, 1'b0); chk("disp2_lw", int'(bus.upc), 3);
        cyc(FETCH, 7'd0, 4'd0, 1'b0);       chk("fetch",    int'(bus.upc), 0);
        cyc(DISP1, 7'b0100011, 4'd0, 1'b0); chk("disp1_sw", int'(bus.upc), 2);
        cyc(DISP2, 7'b0100011, 4'd0, 1'b0); chk("disp2_sw", int'(bus.upc), 5);
        cyc(DISP1, 7'b1101111, 4'd0, 1'b0); chk("disp1_jal", int'(bus.upc), 9);
        cyc(ALUWB, 7'd0, 4'd0, 1'b0);       chk("aluwb",    int'(bus.upc), 7);

        // Illegal opcode: trap and one-cycle pulse.
        cyc(DISP1, 7'b1111111, 4'd0, 1'b0);
        chk("ill_upc", int'(bus.upc), 15);
        chk("ill_hi",  int'(bus.illegal_op), 1);
        cyc(HOLD, 7'd0, 4'd0, 1'b0);
        chk("ill_lo",   int'(bus.illegal_op), 0);
        chk("hold_upc", int'(bus.upc), 15);
        cyc(DISP2, 7'b0110011, 4'd0, 1'b0);
        chk("ill2_hi", int'(bus.illegal_op), 1);
        cyc(HOLD, 7'd0, 4'd0, 1'b1);
        chk("ill_stall_lo", int'(bus.illegal_op), 0);
        chk("ill_stall_upc", int'(bus.upc), 15);

        // Call/return from upc=4.
        cyc(FETCH, 7'd0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(SEQ, 7'd0, 4'd0, 1'b0);
        chk("pre_call_upc", int'(bus.upc), 4);
        cyc(CALL, 7'd0, 4'd12, 1'b0);
        chk("call_upc",   int'(bus.upc), 12);
        chk("call_depth", int'(bus.stack_depth), 1);
        cyc(RET, 7'd0, 4'd0, 1'b0);
        chk("ret_upc",   int'(bus.upc), 5);
        chk("ret_depth", int'(bus.stack_depth), 0);

        // Nesting, overflow, stall freeze, underflow.
        cyc(CALL, 7'd0, 4'd12, 1'b0);       // pushes 6
        cyc(CALL, 7'd0, 4'd3, 1'b0);        // pushes 13
        chk("nest_upc",   int'(bus.upc), 3);
        chk("nest_depth", int'(bus.stack_depth), 2);
        cyc(CALL, 7'd0, 4'd9, 1'b1);
        chk("stall_upc",   int'(bus.upc), 3);
        chk("stall_depth", int'(bus.stack_depth), 2);
        chk("stall_err",   int'(bus.stack_err), 0);
        cyc(CALL, 7'd0, 4'd9, 1'b0);
        chk("ovf_upc",   int'(bus.upc), 15);
        chk("ovf_err",   int'(bus.stack_err), 1);
        chk("ovf_depth", int'(bus.stack_depth), 2);
        cyc(RET, 7'd0, 4'd0, 1'b0); chk("ret1_upc", int'(bus.upc), 13);
        cyc(RET, 7'd0, 4'd0, 1'b0); chk("ret2_upc", int'(bus.upc), 6);
        cyc(RET, 7'd0, 4'd0, 1'b1); chk("ret_stall_upc", int'(bus.upc), 6);
        cyc(RET, 7'd0, 4'd0, 1'b0);
        chk("unf_upc",   int'(bus.upc), 15);
        chk("unf_err",   int'(bus.stack_err), 1);
        chk("unf_depth", int'(bus.stack_depth), 0);
        cyc(FETCH, 7'd0, 4'd0, 1'b0);
        chk("err_sticky", int'(bus.stack_err), 1);

        // Asynchronous reset mid-run at upc=9, depth=1.
        cyc(CALL, 7'd0, 4'd9, 1'b0);
        chk("pre_rst_upc",   int'(bus.upc), 9);
        chk("pre_rst_depth", int'(bus.stack_depth), 1);
        bus.addr_ctl = SEQ;
        #2 reset = 1'b1;
        #1;
        chk("arst_upc",   int'(bus.upc), 0);
        chk("arst_depth", int'(bus.stack_depth), 0);
        chk("arst_err",   int'(bus.stack_err), 0);
        chk("arst_ill",   int'(bus.illegal_op), 0);
        @(negedge clk);
        reset = 1'b0;

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 120; i++) begin
            cyc(3'($urandom_range(0, 7)), op_tab[$urandom_range(0, 7)],
                4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
